msg_capture_buffer: RTL and testbench

//  Parametrised word-capture buffer: collects a message word by word, e.g. keypad/UART ASCII.
//  On commit, publishes the whole message as one flat, registered snapshot bus for the decoder.

---
 rtl/msg_capture_buffer_if.sv | 32 +++
 rtl/msg_capture_buffer.sv | 102 ++++++++++
 tb/tb_msg_capture_buffer.sv | 181 ++++++++++++++++++
 3 files changed

// File: rtl/msg_capture_buffer_if.sv
// Bus bundle between a message producer (keypad/UART front end) and the
// capture buffer. The producer drives the strobes; the buffer drives the
// snapshot and status signals.
interface msg_capture_buffer_if #(
  parameter int DATA_SIZE      = 8,
  parameter int ADDR_SPACE_EXP = 5
);
  localparam int DEPTH = 2 ** ADDR_SPACE_EXP;

  logic                          wr_en;
  logic [DATA_SIZE-1:0]          wr_data;
  logic                          bksp;
  logic                          commit;
  logic                          clear;
  logic [DATA_SIZE*DEPTH-1:0]    snap_data;
  logic [ADDR_SPACE_EXP:0]       snap_count;
  logic                          snap_valid;
  logic [ADDR_SPACE_EXP:0]       count;
  logic                          empty;
  logic                          full;
  logic                          overflow;

  modport master (
    output wr_en, wr_data, bksp, commit, clear,
    input  snap_data, snap_count, snap_valid, count, empty, full, overflow
  );

  modport slave (
    input  wr_en, wr_data, bksp, commit, clear,
    output snap_data, snap_count, snap_valid, count, empty, full, overflow
  );
endinterface

// File: rtl/msg_capture_buffer.sv
// Word-capture buffer: appends words one at a time, supports backspace,
// clear and optional ring overwrite, and on commit publishes the whole
// message (oldest first, pad-filled) as a flat registered snapshot.
module msg_capture_buffer #(
  parameter int                  DATA_SIZE      = 8,
  parameter int                  ADDR_SPACE_EXP = 5,
  parameter int                  RING_MODE      = 0,
  parameter logic [DATA_SIZE-1:0] PAD_WORD      = 8'h20
) (
  input  logic              clk_100MHz,
  input  logic              reset_n,
  msg_capture_buffer_if.slave bus
);
  localparam int DEPTH = 2 ** ADDR_SPACE_EXP;
  localparam int AW    = ADDR_SPACE_EXP;
  localparam int CW    = ADDR_SPACE_EXP + 1;

  logic [DATA_SIZE-1:0]       mem [DEPTH];
  logic [AW-1:0]              wr_ptr;
  logic [CW-1:0]              count_q;
  logic                       overflow_q;
  logic [DATA_SIZE*DEPTH-1:0] snap_data_q;
  logic [CW-1:0]              snap_count_q;
  logic                       snap_valid_q;

  logic                       is_full;
  logic                       mem_we;
  logic [DATA_SIZE*DEPTH-1:0] snap_next;
  logic [AW-1:0]              rd_idx;

  assign is_full = (count_q == CW'(DEPTH));

  // Only a write that survives the clear > commit > bksp > wr_en priority
  // touches storage; a full non-ring buffer drops the word.
  assign mem_we = bus.wr_en && !bus.clear && !bus.commit && !bus.bksp &&
                  (!is_full || (RING_MODE != 0));

  // Storage write; contents are deliberately not reset.
  always_ff @(posedge clk_100MHz) begin
    if (mem_we) mem[wr_ptr] <= bus.wr_data;
  end

  // Assemble the snapshot oldest-first. When count == DEPTH the low bits of
  // count are zero, so the oldest word sits at wr_ptr, which is what ring
  // overwrite needs.
  always_comb begin
    snap_next = '0;
    rd_idx    = '0;
    for (int i = 0; i < DEPTH; i++) begin
      rd_idx = wr_ptr - count_q[AW-1:0] + AW'(i);
      if (CW'(i) < count_q) snap_next[i*DATA_SIZE +: DATA_SIZE] = mem[rd_idx];
      else                  snap_next[i*DATA_SIZE +: DATA_SIZE] = PAD_WORD;
    end
  end

  // Control: pointer, occupancy, sticky overflow and snapshot registers.
  always_ff @(posedge clk_100MHz or negedge reset_n) begin
    if (!reset_n) begin
      wr_ptr       <= '0;
      count_q      <= '0;
      overflow_q   <= 1'b0;
      snap_data_q  <= '0;
      snap_count_q <= '0;
      snap_valid_q <= 1'b0;
    end else begin
      snap_valid_q <= 1'b0;
      if (bus.clear) begin
        wr_ptr     <= '0;
        count_q    <= '0;
        overflow_q <= 1'b0;
      end else if (bus.commit) begin
        snap_data_q  <= snap_next;
        snap_count_q <= count_q;
        snap_valid_q <= 1'b1;
        wr_ptr       <= '0;
        count_q      <= '0;
        overflow_q   <= 1'b0;
      end else if (bus.bksp) begin
        if (count_q != '0) begin
          wr_ptr  <= wr_ptr - AW'(1);
          count_q <= count_q - CW'(1);
        end
      end else if (bus.wr_en) begin
        if (!is_full) begin
          wr_ptr  <= wr_ptr + AW'(1);
          count_q <= count_q + CW'(1);
        end else begin
          overflow_q <= 1'b1;
          if (RING_MODE != 0) wr_ptr <= wr_ptr + AW'(1);
        end
      end
    end
  end

  assign bus.snap_data  = snap_data_q;
  assign bus.snap_count = snap_count_q;
  assign bus.snap_valid = snap_valid_q;
  assign bus.count      = count_q;
  assign bus.empty      = (count_q == '0);
  assign bus.full       = is_full;
  assign bus.overflow   = overflow_q;
endmodule

// File: tb/tb_msg_capture_buffer.sv
// Directed bench: a drop-mode and a ring-mode buffer see identical stimulus
// and are checked against hand-computed values.
module tb_msg_capture_buffer;
  logic clk_100MHz = 1'b0;
  logic reset_n    = 1'b0;

  logic       wr_en  = 1'b0;
  logic [7:0] wr_data = 8'h00;
  logic       bksp   = 1'b0;
  logic       commit = 1'b0;
  logic       clear  = 1'b0;

  int checks   = 0;
  int failures = 0;

  always #5 clk_100MHz = ~clk_100MHz;

  msg_capture_buffer_if #(.DATA_SIZE(8), .ADDR_SPACE_EXP(5)) bus0 ();
  msg_capture_buffer_if #(.DATA_SIZE(8), .ADDR_SPACE_EXP(5)) bus1 ();

  assign bus0.wr_en = wr_en;  assign bus1.wr_en = wr_en;
  assign bus0.wr_data = wr_data;  assign bus1.wr_data = wr_data;
  assign bus0.bksp = bksp;  assign bus1.bksp = bksp;
  assign bus0.commit = commit;  assign bus1.commit = commit;
  assign bus0.clear = clear;  assign bus1.clear = clear;

  msg_capture_buffer #(.DATA_SIZE(8), .ADDR_SPACE_EXP(5), .RING_MODE(0), .PAD_WORD(8'h20))
    dut0 (.clk_100MHz(clk_100MHz), .reset_n(reset_n), .bus(bus0));
  msg_capture_buffer #(.DATA_SIZE(8), .ADDR_SPACE_EXP(5), .RING_MODE(1), .PAD_WORD(8'h20))
    dut1 (.clk_100MHz(clk_100MHz), .reset_n(reset_n), .bus(bus1));

  task automatic chk(input string tag, input logic [63:0] got, input logic [63:0] exp);
    checks++;
    if (got !== exp) begin
      failures++;
      $display("FAIL %s got=%0h exp=%0h", tag, got, exp);
    end
  endtask

  function automatic logic [7:0] slot(input logic [255:0] v, input int i);
    return v[i*8 +: 8];
  endfunction

  task automatic tick();
    @(posedge clk_100MHz);
    #1;
  endtask

  task automatic put(input logic [7:0] d);
    wr_en = 1'b1; wr_data = d;
    tick();
    wr_en = 1'b0;
  endtask

  task automatic do_commit();
    commit = 1'b1;
    tick();
    commit = 1'b0;
  endtask

  logic [255:0] held;

  initial begin
    // 1: reset, then reset asserted mid-write
    repeat (2) tick();
    chk("rst_count", bus0.count, 0);
    chk("rst_empty", bus0.empty, 1);
    chk("rst_full", bus0.full, 0);
    chk("rst_snap_data", bus0.snap_data[63:0], 0);
    chk("rst_snap_valid", bus0.snap_valid, 0);
    reset_n = 1'b1;
    tick();
    put(8'h11); put(8'h22);
    wr_en = 1'b1; wr_data = 8'h33;
    #3 reset_n = 1'b0;
    #1;
    chk("midrst_count", bus0.count, 0);
    chk("midrst_empty", bus0.empty, 1);
    tick();
    wr_en = 1'b0;
    reset_n = 1'b1;
    tick();

    // 2: "ABC" commit
    put(8'h41); put(8'h42); put(8'h43);
    chk("abc_count", bus0.count, 3);
    do_commit();
    chk("abc_valid", bus0.snap_valid, 1);
    chk("abc_snap_count", bus0.snap_count, 3);
    chk("abc_s0", slot(bus0.snap_data, 0), 8'h41);
    chk("abc_s1", slot(bus0.snap_data, 1), 8'h42);
    chk("abc_s2", slot(bus0.snap_data, 2), 8'h43);
    chk("abc_s3", slot(bus0.snap_data, 3), 8'h20);
    chk("abc_s31", slot(bus0.snap_data, 31), 8'h20);
    chk("abc_count_after", bus0.count, 0);
    tick();
    chk("abc_valid_drop", bus0.snap_valid, 0);

    // 3: backspace
    put(8'h41); put(8'h42);
    bksp = 1'b1; tick(); bksp = 1'b0;
    chk("bksp_count", bus0.count, 1);
    put(8'h5A);
    do_commit();
    chk("bksp_snap_count", bus0.snap_count, 2);
    chk("bksp_s0", slot(bus0.snap_data, 0), 8'h41);
    chk("bksp_s1", slot(bus0.snap_data, 1), 8'h5A);
    chk("bksp_s2", slot(bus0.snap_data, 2), 8'h20);
    bksp = 1'b1; tick(); bksp = 1'b0;
    chk("bksp_empty_count", bus0.count, 0);
    chk("bksp_empty_flag", bus0.empty, 1);

    // 6: clear beats commit and write; snapshot holds
    for (int i = 0; i < 5; i++) put(8'h60 + 8'(i));
    chk("pre_clear_count", bus0.count, 5);
    clear = 1'b1; commit = 1'b1; wr_en = 1'b1; wr_data = 8'h77;
    tick();
    clear = 1'b0; commit = 1'b0; wr_en = 1'b0;
    chk("clr_count", bus0.count, 0);
    chk("clr_valid", bus0.snap_valid, 0);
    chk("clr_snap_count", bus0.snap_count, 2);
    chk("clr_s0", slot(bus0.snap_data, 0), 8'h41);
    chk("clr_s1", slot(bus0.snap_data, 1), 8'h5A);
    // commit beats write
    put(8'h78); put(8'h79); put(8'h7A);
    commit = 1'b1; wr_en = 1'b1; wr_data = 8'h55;
    tick();
    commit = 1'b0; wr_en = 1'b0;
    chk("cw_valid", bus0.snap_valid, 1);
    chk("cw_snap_count", bus0.snap_count, 3);
    chk("cw_s2", slot(bus0.snap_data, 2), 8'h7A);
    chk("cw_s3", slot(bus0.snap_data, 3), 8'h20);
    chk("cw_count", bus0.count, 0);

    // empty commit
    do_commit();
    chk("ecommit_valid", bus0.snap_valid, 1);
    chk("ecommit_snap_count", bus0.snap_count, 0);
    chk("ecommit_s0", slot(bus0.snap_data, 0), 8'h20);

    // 4: 33 writes
    for (int i = 0; i < 33; i++) put(8'(i));
    chk("drop_count", bus0.count, 32);
    chk("drop_full", bus0.full, 1);
    chk("drop_ovf", bus0.overflow, 1);
    chk("ring33_count", bus1.count, 32);
    chk("ring33_ovf", bus1.overflow, 1);
    do_commit();
    chk("drop_s0", slot(bus0.snap_data, 0), 8'd0);
    chk("drop_s31", slot(bus0.snap_data, 31), 8'd31);
    chk("ring33_s0", slot(bus1.snap_data, 0), 8'd1);
    chk("ring33_s31", slot(bus1.snap_data, 31), 8'd32);
    chk("drop_ovf_cleared", bus0.overflow, 0);

    // 5: 34 writes
    for (int i = 0; i < 34; i++) put(8'(i));
    chk("ring_count", bus1.count, 32);
    chk("ring_ovf", bus1.overflow, 1);
    chk("ring_full", bus1.full, 1);
    do_commit();
    chk("ring_snap_count", bus1.snap_count, 32);
    chk("ring_s0", slot(bus1.snap_data, 0), 8'd2);
    chk("ring_s31", slot(bus1.snap_data, 31), 8'd33);
    chk("drop34_s31", slot(bus0.snap_data, 31), 8'd31);
    chk("ring_ovf_cleared", bus1.overflow, 0);

    // reset clears a held snapshot
    held = bus1.snap_data;
    chk("held_nonzero", (held != 256'd0), 1);
    #2 reset_n = 1'b0;
    #1;
    chk("final_rst_snap_count", bus1.snap_count, 0);
    chk("final_rst_snap_s0", slot(bus1.snap_data, 0), 8'h00);
    chk("final_rst_snap_s31", slot(bus1.snap_data, 31), 8'h00);
    reset_n = 1'b1;
    tick();

    $display("TB_RESULT checks=%0d failures=%0d", checks, failures);
    $finish;
  end
endmodule
